// File: rtl/exception_ctrl_pkg.sv
// rtl/exception_ctrl_pkg.sv - shared defines for the CP0 exception initiator
//
// Purpose: ExcCode constants, per-slot exception-vector bit indices, CP0
// register numbers and the redirect FSM state encoding.
// Ports: none (package).
package exception_ctrl_pkg;

  // ExcCode values as written into CP0 Cause.ExcCode
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;
  localparam logic [4:0] EXC_TR   = 5'd13;
  localparam logic [4:0] EXC_ERET = 5'h0e;

  // Bit positions in the per-slot exception vector. Bit 0 is the highest
  // priority synchronous cause, bit 8 the lowest.
  localparam int EV_IF_ADEL = 0;
  localparam int EV_RI      = 1;
  localparam int EV_OV      = 2;
  localparam int EV_TR      = 3;
  localparam int EV_SYS     = 4;
  localparam int EV_BP      = 5;
  localparam int EV_ERET    = 6;
  localparam int EV_LD_ADEL = 7;
  localparam int EV_ST_ADES = 8;
  localparam int EV_W       = 9;

  // CP0 register numbers
  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;
  localparam logic [4:0] CP0_EBASE  = 5'd15;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_REDIR = 1'b1
  } exc_state_e;

endpackage

// File: rtl/exception_ctrl_if.sv
// rtl/exception_ctrl_if.sv - CP0 exception report and fetch redirect bundle
//
// Purpose: groups the signals exception_ctrl drives toward CP0 and fetch.
// Signals:
//   exception_flag/type/first_inst  exception committed this cycle (to CP0)
//   kill_slot2                      suppress slot2 writeback
//   flush                           one-cycle pipeline flush pulse
//   new_pc/new_pc_valid             redirect target, held until accepted
//   fetch_ready                     fetch accepts the redirect
// Modports: master = exception_ctrl, slave = CP0/fetch side.
interface exception_ctrl_if;
  logic        exception_flag;
  logic [4:0]  exception_type;
  logic        exception_first_inst;
  logic        kill_slot2;
  logic        flush;
  logic [31:0] new_pc;
  logic        new_pc_valid;
  logic        fetch_ready;

  modport master (
    output exception_flag, exception_type, exception_first_inst, kill_slot2,
    output flush, new_pc, new_pc_valid,
    input  fetch_ready
  );

  modport slave (
    input  exception_flag, exception_type, exception_first_inst, kill_slot2,
    input  flush, new_pc, new_pc_valid,
    output fetch_ready
  );
endinterface

// File: rtl/exception_ctrl_prio_enc.sv
// rtl/exception_ctrl_prio_enc.sv - per-slot exception priority encoder
//
// Purpose: picks the winning cause for one issue slot.
// Ports:
//   exc_i      in  9  slot exception vector (already gated by slot valid)
//   int_i      in  1  interrupt attached to this slot
//   hit_o      out 1  slot takes an exception
//   code_o     out 5  ExcCode (or ERET_CODE)
//   is_eret_o  out 1  winning cause is ERET
module exc_prio_enc
  import exception_ctrl_pkg::*;
#(
  parameter logic [4:0] ERET_CODE = EXC_ERET
) (
  input  logic [EV_W-1:0] exc_i,
  input  logic            int_i,
  output logic            hit_o,
  output logic [4:0]      code_o,
  output logic            is_eret_o
);

  always_comb begin
    hit_o     = int_i | (|exc_i);
    code_o    = EXC_INT;
    is_eret_o = 1'b0;
    if (int_i)                   code_o = EXC_INT;
    else if (exc_i[EV_IF_ADEL])  code_o = EXC_ADEL;
    else if (exc_i[EV_RI])       code_o = EXC_RI;
    else if (exc_i[EV_OV])       code_o = EXC_OV;
    else if (exc_i[EV_TR])       code_o = EXC_TR;
    else if (exc_i[EV_SYS])      code_o = EXC_SYS;
    else if (exc_i[EV_BP])       code_o = EXC_BP;
    else if (exc_i[EV_ERET]) begin
      code_o    = ERET_CODE;
      is_eret_o = 1'b1;
    end
    else if (exc_i[EV_LD_ADEL])  code_o = EXC_ADEL;
    else if (exc_i[EV_ST_ADES])  code_o = EXC_ADES;
  end

endmodule

// File: rtl/exception_ctrl.sv
// rtl/exception_ctrl.sv - CP0 exception initiator at the MEM/commit boundary
//
// Purpose: prioritises exceptions of both issue slots and the pending
// interrupt, reports the winner to CP0, then flushes the pipeline and holds
// the redirect PC toward fetch until it is accepted.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   slot1/2_valid_i, _exc_i  commit-stage slots and their exception vectors
//   mem_stall_i              commit stalled, no exception may be taken
//   status_i/cause_i/epc_i/ebase_i   CP0 state
//   cp0_we_i/waddr_i/wsel_i/wdata_i  WB-stage mtc0 (bypass source)
//   bus                      exception_ctrl_if.master (CP0 report, redirect)
// Configuration: EXC_CTRL_CP0_BYPASS_EN forwards a same-cycle mtc0 to
// EPC/Status/Cause/EBase; undefined means raw CP0 values are used.
module exception_ctrl
  import exception_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_OFFSET = 32'h0000_0000,
  parameter logic [4:0]  ERET_CODE  = EXC_ERET
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            slot1_valid_i,
  input  logic            slot2_valid_i,
  input  logic [EV_W-1:0] slot1_exc_i,
  input  logic [EV_W-1:0] slot2_exc_i,
  input  logic            mem_stall_i,
  input  logic [31:0]     status_i,
  input  logic [31:0]     cause_i,
  input  logic [31:0]     epc_i,
  input  logic [31:0]     ebase_i,
  input  logic            cp0_we_i,
  input  logic [4:0]      cp0_waddr_i,
  input  logic [2:0]      cp0_wsel_i,
  input  logic [31:0]     cp0_wdata_i,
  exception_ctrl_if.master bus
);

  logic [31:0] eff_status, eff_cause, eff_epc, eff_ebase;
  logic        unused_ok;

`ifdef EXC_CTRL_CP0_BYPASS_EN
  logic wr_sel0;
  assign wr_sel0 = cp0_we_i & (cp0_wsel_i == 3'd0);

  always_comb begin
    eff_status = status_i;
    eff_cause  = cause_i;
    eff_epc    = epc_i;
    eff_ebase  = ebase_i;
    if (wr_sel0 && cp0_waddr_i == CP0_STATUS) begin
      eff_status[15:8] = cp0_wdata_i[15:8];
      eff_status[1:0]  = cp0_wdata_i[1:0];
    end
    if (wr_sel0 && cp0_waddr_i == CP0_CAUSE)
      eff_cause[9:8] = cp0_wdata_i[9:8];
    if (wr_sel0 && cp0_waddr_i == CP0_EPC)
      eff_epc = cp0_wdata_i;
    if (cp0_we_i && cp0_wsel_i == 3'd1 && cp0_waddr_i == CP0_EBASE)
      eff_ebase = cp0_wdata_i;
  end

  assign unused_ok = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};
`else
  assign eff_status = status_i;
  assign eff_cause  = cause_i;
  assign eff_epc    = epc_i;
  assign eff_ebase  = ebase_i;
  assign unused_ok  = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0],
                        cp0_we_i, cp0_waddr_i, cp0_wsel_i, cp0_wdata_i};
`endif

  // Interrupt needs an unmasked pending line, IE set and EXL clear
  logic int_pend;
  assign int_pend = (|(eff_cause[15:8] & eff_status[15:8])) & eff_status[0] & ~eff_status[1];

  // The interrupt rides on the oldest valid instruction
  logic            int1, int2;
  logic [EV_W-1:0] vec1, vec2;
  assign int1 = int_pend & slot1_valid_i;
  assign int2 = int_pend & ~slot1_valid_i & slot2_valid_i;
  assign vec1 = slot1_valid_i ? slot1_exc_i : '0;
  assign vec2 = slot2_valid_i ? slot2_exc_i : '0;

  logic       hit1, hit2, eret1, eret2;
  logic [4:0] code1, code2;

  exc_prio_enc #(.ERET_CODE(ERET_CODE)) u_enc_slot1 (
    .exc_i(vec1), .int_i(int1), .hit_o(hit1), .code_o(code1), .is_eret_o(eret1)
  );
  exc_prio_enc #(.ERET_CODE(ERET_CODE)) u_enc_slot2 (
    .exc_i(vec2), .int_i(int2), .hit_o(hit2), .code_o(code2), .is_eret_o(eret2)
  );

  exc_state_e  state_q, state_d;
  logic        flush_q, flush_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic        new_pc_valid_q, new_pc_valid_d;

  logic        take;
  logic        sel_eret;
  logic [31:0] target;

  // Slot inputs are bubbles during REDIR, so nothing is taken there
  assign take     = (state_q == ST_IDLE) & ~rst & ~mem_stall_i & (hit1 | hit2);
  assign sel_eret = hit1 ? eret1 : eret2;
  assign target   = sel_eret ? eff_epc : (eff_ebase + EXC_OFFSET);

  assign bus.exception_flag       = take;
  assign bus.exception_type       = take ? (hit1 ? code1 : code2) : 5'd0;
  assign bus.exception_first_inst = take & hit1;
  assign bus.kill_slot2           = take & hit1 & slot2_valid_i;
  assign bus.flush                = flush_q;
  assign bus.new_pc               = new_pc_q;
  assign bus.new_pc_valid         = new_pc_valid_q;

  always_comb begin
    state_d        = state_q;
    flush_d        = 1'b0;
    new_pc_d       = new_pc_q;
    new_pc_valid_d = new_pc_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (take) begin
          state_d        = ST_REDIR;
          flush_d        = 1'b1;
          new_pc_d       = target;
          new_pc_valid_d = 1'b1;
        end
      end
      ST_REDIR: begin
        if (bus.fetch_ready) begin
          state_d        = ST_IDLE;
          new_pc_d       = 32'd0;
          new_pc_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      flush_q        <= 1'b0;
      new_pc_q       <= 32'd0;
      new_pc_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      flush_q        <= flush_d;
      new_pc_q       <= new_pc_d;
      new_pc_valid_q <= new_pc_valid_d;
    end
  end

endmodule

// File: tb/tb_exception_ctrl.sv
// tb/tb_exception_ctrl.sv - self-checking bench for exception_ctrl
module tb_exception_ctrl;

  localparam logic [31:0] OFFSET = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        slot1_valid, slot2_valid;
  logic [8:0]  slot1_exc, slot2_exc;
  logic        mem_stall;
  logic [31:0] status, cause, epc, ebase;
  logic        cp0_we;
  logic [4:0]  cp0_waddr;
  logic [2:0]  cp0_wsel;
  logic [31:0] cp0_wdata;

  int checks = 0;
  int errors = 0;

  exception_ctrl_if bus ();

  exception_ctrl #(.EXC_OFFSET(OFFSET)) dut (
    .clk(clk), .rst(rst),
    .slot1_valid_i(slot1_valid), .slot2_valid_i(slot2_valid),
    .slot1_exc_i(slot1_exc), .slot2_exc_i(slot2_exc),
    .mem_stall_i(mem_stall),
    .status_i(status), .cause_i(cause), .epc_i(epc), .ebase_i(ebase),
    .cp0_we_i(cp0_we), .cp0_waddr_i(cp0_waddr), .cp0_wsel_i(cp0_wsel),
    .cp0_wdata_i(cp0_wdata),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Priority order of the vector bits (bit 0 first) mapped to ExcCode
  function automatic logic [4:0] code_of(input int b);
    case (b)
      0: return 5'd4;   1: return 5'd10;  2: return 5'd12;
      3: return 5'd13;  4: return 5'd8;   5: return 5'd9;
      6: return 5'h0e;  7: return 5'd4;   default: return 5'd5;
    endcase
  endfunction

  // Reference decision: which slot wins, with what code and target
  function automatic void decide(output bit hit, output logic [4:0] code,
                                 output bit first, output logic [31:0] tgt);
    logic [31:0] st, ca, ep, eb;
    bit          ip;
    bit          v[2];
    logic [8:0]  e[2];
    st = status; ca = cause; ep = epc; eb = ebase;
`ifdef EXC_CTRL_CP0_BYPASS_EN
    if (cp0_we && cp0_wsel == 3'd0 && cp0_waddr == 5'd12) begin
      st[15:8] = cp0_wdata[15:8];
      st[1:0]  = cp0_wdata[1:0];
    end
    if (cp0_we && cp0_wsel == 3'd0 && cp0_waddr == 5'd13) ca[9:8] = cp0_wdata[9:8];
    if (cp0_we && cp0_wsel == 3'd0 && cp0_waddr == 5'd14) ep = cp0_wdata;
    if (cp0_we && cp0_wsel == 3'd1 && cp0_waddr == 5'd15) eb = cp0_wdata;
`endif
    ip = ((ca[15:8] & st[15:8]) != 8'd0) && st[0] && !st[1];
    v[0] = slot1_valid; v[1] = slot2_valid;
    e[0] = slot1_exc;   e[1] = slot2_exc;
    hit = 0; code = 5'd0; first = 0; tgt = 32'd0;
    for (int s = 0; s < 2; s++) begin
      if (!hit && v[s]) begin
        if (ip) begin
          hit = 1; code = 5'd0; first = (s == 0); tgt = eb + OFFSET;
        end else begin
          for (int b = 0; b < 9; b++) begin
            if (!hit && e[s][b]) begin
              hit = 1; code = code_of(b); first = (s == 0);
              tgt = (b == 6) ? ep : eb + OFFSET;
            end
          end
        end
      end
    end
  endfunction

  // Transaction-level model of the redirect: busy, its target, flush pulse
  bit          m_busy  = 0;
  bit          m_flush = 0;
  logic [31:0] m_pc    = 32'd0;

  always @(posedge clk) begin
    bit h, f, fl;
    logic [4:0]  c;
    logic [31:0] t;
    decide(h, c, f, t);
    fl = !rst && !m_busy && !mem_stall && h;
    if (rst) begin
      m_busy <= 0; m_flush <= 0; m_pc <= 32'd0;
    end else if (!m_busy) begin
      m_flush <= fl;
      if (fl) begin m_busy <= 1; m_pc <= t; end
    end else begin
      m_flush <= 0;
      if (bus.fetch_ready) begin m_busy <= 0; m_pc <= 32'd0; end
    end
  end

  bit model_on = 0;

  always @(negedge clk) begin
    bit h, f, fl;
    logic [4:0]  c;
    logic [31:0] t;
    if (model_on) begin
      decide(h, c, f, t);
      fl = !rst && !m_busy && !mem_stall && h;
      chk("m_flag",  32'(bus.exception_flag), 32'(fl));
      chk("m_type",  32'(bus.exception_type), fl ? 32'(c) : 32'd0);
      chk("m_first", 32'(bus.exception_first_inst), 32'(fl && f));
      chk("m_kill",  32'(bus.kill_slot2), 32'(fl && f && slot2_valid));
      chk("m_flush", 32'(bus.flush), 32'(m_flush));
      chk("m_valid", 32'(bus.new_pc_valid), 32'(m_busy));
      chk("m_pc",    bus.new_pc, m_pc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_slots();
    slot1_valid = 0; slot2_valid = 0; slot1_exc = 9'd0; slot2_exc = 9'd0;
    cp0_we = 0;
  endtask

  task automatic accept();
    bus.fetch_ready = 1;
    step();
    bus.fetch_ready = 0;
  endtask

  initial begin
    rst = 1; clear_slots(); mem_stall = 0;
    status = 0; cause = 0; epc = 0; ebase = 0;
    cp0_waddr = 0; cp0_wsel = 0; cp0_wdata = 0; bus.fetch_ready = 0;
    step(); step();
    model_on = 1;
    step();
    @(negedge clk);
    chk("rst_flag",  32'(bus.exception_flag), 32'd0);
    chk("rst_valid", 32'(bus.new_pc_valid), 32'd0);
    chk("rst_pc",    bus.new_pc, 32'd0);
    chk("rst_flush", 32'(bus.flush), 32'd0);
    rst = 0;
    step();

    // slot1 ov beats slot2 sys
    slot1_valid = 1; slot1_exc = 9'b000000100;
    slot2_valid = 1; slot2_exc = 9'b000010000;
    ebase = 32'hBFC0_0380;
    @(negedge clk);
    chk("t1_flag",  32'(bus.exception_flag), 32'd1);
    chk("t1_type",  32'(bus.exception_type), 32'd12);
    chk("t1_first", 32'(bus.exception_first_inst), 32'd1);
    chk("t1_kill",  32'(bus.kill_slot2), 32'd1);
    step(); clear_slots();
    @(negedge clk);
    chk("t1_flush", 32'(bus.flush), 32'd1);
    chk("t1_pc",    bus.new_pc, 32'hBFC0_0380);
    chk("t1_valid", 32'(bus.new_pc_valid), 32'd1);

    // REDIR held with fetch_ready low; a new ri must not be reported
    step(); slot1_valid = 1; slot1_exc = 9'b000000010;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t5_flush", 32'(bus.flush), 32'd0);
      chk("t5_valid", 32'(bus.new_pc_valid), 32'd1);
      chk("t5_pc",    bus.new_pc, 32'hBFC0_0380);
      chk("t6_flag",  32'(bus.exception_flag), 32'd0);
      step();
    end
    clear_slots(); bus.fetch_ready = 1;
    @(negedge clk);
    chk("t6_valid_hold", 32'(bus.new_pc_valid), 32'd1);
    step(); bus.fetch_ready = 0;
    @(negedge clk);
    chk("t6_valid_drop", 32'(bus.new_pc_valid), 32'd0);

    // slot2 ERET behind a clean slot1
    step();
    slot1_valid = 1; slot2_valid = 1; slot2_exc = 9'b001000000; epc = 32'h8000_1234;
    @(negedge clk);
    chk("t2_type",  32'(bus.exception_type), 32'h0e);
    chk("t2_first", 32'(bus.exception_first_inst), 32'd0);
    chk("t2_kill",  32'(bus.kill_slot2), 32'd0);
    step(); clear_slots();
    @(negedge clk);
    chk("t2_pc", bus.new_pc, 32'h8000_1234);
    accept();

    // interrupt beats bp; EXL masks it
    status = 32'h0000_0401; cause = 32'h0000_0400;
    slot1_valid = 1; slot1_exc = 9'b000100000;
    @(negedge clk);
    chk("t3_type", 32'(bus.exception_type), 32'd0);
    chk("t3_flag", 32'(bus.exception_flag), 32'd1);
    step(); clear_slots(); accept();
    status = 32'h0000_0403;
    slot1_valid = 1; slot1_exc = 9'b000100000;
    @(negedge clk);
    chk("t4_type", 32'(bus.exception_type), 32'd9);
    step(); clear_slots(); accept();
    status = 0; cause = 0;

    // stall holds off the decision
    mem_stall = 1; slot1_valid = 1; slot1_exc = 9'b000000010;
    @(negedge clk);
    chk("t7_stall_flag", 32'(bus.exception_flag), 32'd0);
    step(); mem_stall = 0;
    @(negedge clk);
    chk("t7_type", 32'(bus.exception_type), 32'd10);
    step(); clear_slots(); accept();

`ifdef EXC_CTRL_CP0_BYPASS_EN
    epc = 0; slot1_valid = 1; slot1_exc = 9'b001000000;
    cp0_we = 1; cp0_waddr = 5'd14; cp0_wsel = 3'd0; cp0_wdata = 32'h8000_2000;
    @(negedge clk);
    chk("t8_type", 32'(bus.exception_type), 32'h0e);
    step(); clear_slots();
    @(negedge clk);
    chk("t8_pc", bus.new_pc, 32'h8000_2000);
    accept();
`endif

    // reset while redirecting
    slot1_valid = 1; slot1_exc = 9'b000000010;
    step(); clear_slots();
    @(negedge clk);
    chk("t9_pre_valid", 32'(bus.new_pc_valid), 32'd1);
    rst = 1;
    step();
    @(negedge clk);
    chk("t9_valid", 32'(bus.new_pc_valid), 32'd0);
    chk("t9_flush", 32'(bus.flush), 32'd0);
    chk("t9_pc",    bus.new_pc, 32'd0);
    chk("t9_flag",  32'(bus.exception_flag), 32'd0);
    rst = 0;

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      step();
      rst         = ($urandom_range(0, 63) == 0);
      slot1_valid = ($urandom_range(0, 3) != 0);
      slot2_valid = ($urandom_range(0, 3) != 0);
      slot1_exc   = 9'($urandom & $urandom & $urandom);
      slot2_exc   = 9'($urandom & $urandom & $urandom);
      mem_stall   = ($urandom_range(0, 3) == 0);
      status      = $urandom;
      cause       = ($urandom & 32'hFFFF_00FF) | ($urandom & $urandom & $urandom & 32'h0000_FF00);
      epc         = $urandom;
      ebase       = $urandom;
      cp0_we      = ($urandom_range(0, 3) == 0);
      cp0_waddr   = 5'($urandom_range(12, 15));
      cp0_wsel    = 3'($urandom_range(0, 1));
      cp0_wdata   = $urandom;
      bus.fetch_ready = ($urandom_range(0, 1) == 1);
    end
    step();
    model_on = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
